// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with static BTFN fallback on miss.
// Fetch side predicts combinationally; execute side resolves, flags mispredicts and trains.
// Optional statistics counters are compiled in with the BP_STATS_EN macro.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // fetch-side lookup
    input  logic [63:0] f_PC_i,
    input  logic [3:0]  f_icode_i,
    input  logic [3:0]  f_ifun_i,
    input  logic [63:0] f_valC_i,
    input  logic [63:0] f_valP_i,
    output logic        f_pred_taken_o,
    output logic [63:0] f_predPC_o,
    // execute-side update
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_ifun_i,
    input  logic [63:0] E_PC_i,
    input  logic [63:0] E_valC_i,
    input  logic [63:0] E_valP_i,
    input  logic        E_pred_taken_i,
    input  logic        e_Cnd_i,
    input  logic        upd_en_i,
    output logic        e_mispredict_o,
    output logic [63:0] e_corrPC_o,
    // statistics
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit, e_cond, upd;

    assign f_idx = f_PC_i[IDX_W-1:0];
    assign f_tag = f_PC_i[IDX_W+TAG_W-1:IDX_W];
    assign e_idx = E_PC_i[IDX_W-1:0];
    assign e_tag = E_PC_i[IDX_W+TAG_W-1:IDX_W];

    // PC bits above the tag do not participate in indexing or matching
    logic unused_pc;
    assign unused_pc = ^{f_PC_i[63:IDX_W+TAG_W], E_PC_i[63:IDX_W+TAG_W]};

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_cond = (E_icode_i == 4'h7) && (E_ifun_i != 4'h0);
    // Reset drops any coincident update
    assign upd    = e_cond && upd_en_i && !rst_i;

    assign e_mispredict_o = upd && (E_pred_taken_i != e_Cnd_i);
    assign e_corrPC_o     = e_Cnd_i ? E_valC_i : E_valP_i;

    // Fetch lookup: jmp always taken, cond uses counter on hit else backward-taken
    always_comb begin
        f_pred_taken_o = 1'b0;
        f_predPC_o     = f_valP_i;
        if (f_icode_i == 4'h7) begin
            if (f_ifun_i == 4'h0) begin
                f_pred_taken_o = 1'b1;
            end else if (f_hit) begin
                f_pred_taken_o = ctr_q[f_idx][1];
            end else begin
                f_pred_taken_o = (f_valC_i < f_PC_i);
            end
            if (f_pred_taken_o) begin
                f_predPC_o = f_valC_i;
            end
        end
    end

    // Table next state: train counter on hit, replace entry on miss
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        if (upd) begin
            if (e_hit) begin
                if (e_Cnd_i && (ctr_q[e_idx] != 2'b11)) begin
                    ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                end else if (!e_Cnd_i && (ctr_q[e_idx] != 2'b00)) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
            end else begin
                valid_d[e_idx] = 1'b1;
                tag_d[e_idx]   = e_tag;
                ctr_d[e_idx]   = e_Cnd_i ? 2'b10 : 2'b01;
            end
        end
    end

    // Table state register with synchronous clear to weakly-not-taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

    // Saturating statistics next state
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (e_mispredict_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign branch_cnt_o  = 32'd0;
    assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus hand sequences for reset/statistics.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] f_pc, f_valc, f_valp, e_pc, e_valc, e_valp;
    logic [3:0]  f_icode, f_ifun, e_icode, e_ifun;
    logic        e_pred, e_cnd, upd_en;
    logic        f_taken, e_mis;
    logic [63:0] f_ppc, e_corr;
    logic [31:0] br_cnt, mis_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BP_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    branch_predictor #(.ENTRIES(16), .TAG_W(10)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .f_PC_i         (f_pc),
        .f_icode_i      (f_icode),
        .f_ifun_i       (f_ifun),
        .f_valC_i       (f_valc),
        .f_valP_i       (f_valp),
        .f_pred_taken_o (f_taken),
        .f_predPC_o     (f_ppc),
        .E_icode_i      (e_icode),
        .E_ifun_i       (e_ifun),
        .E_PC_i         (e_pc),
        .E_valC_i       (e_valc),
        .E_valP_i       (e_valp),
        .E_pred_taken_i (e_pred),
        .e_Cnd_i        (e_cnd),
        .upd_en_i       (upd_en),
        .e_mispredict_o (e_mis),
        .e_corrPC_o     (e_corr),
        .branch_cnt_o   (br_cnt),
        .mispred_cnt_o  (mis_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [63:0] fpc;
        logic [3:0]  ficode;
        logic [3:0]  fifun;
        logic [63:0] fvalc;
        logic [63:0] fvalp;
        logic [3:0]  eicode;
        logic [3:0]  eifun;
        logic [63:0] epc;
        logic        epred;
        logic        ecnd;
        logic        upd;
        logic        x_taken;
        logic [63:0] x_ppc;
        logic        x_mis;
        logic [63:0] x_corr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [63:0] fpc, logic [3:0] fic, logic [3:0] fif,
                                logic [63:0] fvc, logic [63:0] fvp, logic [3:0] eic,
                                logic [3:0] eif, logic [63:0] epc, logic ep, logic ec, logic u,
                                logic xt, logic [63:0] xp, logic xm, logic [63:0] xc);
        vec_t v;
        v.rst = r; v.fpc = fpc; v.ficode = fic; v.fifun = fif; v.fvalc = fvc; v.fvalp = fvp;
        v.eicode = eic; v.eifun = eif; v.epc = epc; v.epred = ep; v.ecnd = ec; v.upd = u;
        v.x_taken = xt; v.x_ppc = xp; v.x_mis = xm; v.x_corr = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_f(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] ifn,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_pc = pc; f_icode = ic; f_ifun = ifn; f_valc = vc; f_valp = vp;
    endtask

    task automatic set_e(input logic [63:0] pc, input logic p, input logic c, input logic u);
        e_icode = 4'h7; e_ifun = 4'h1; e_pc = pc; e_pred = p; e_cnd = c; upd_en = u;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // {pred, cnd} for five trained updates, two of which mispredict
    logic [1:0] seq5 [5] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b00};

    initial begin
        e_valc = 64'h300;
        e_valp = 64'h209;
        rst = 1'b1;
        set_f(64'h100, 4'h7, 4'h1, 64'h80, 64'h109);
        set_e(64'h100, 1'b0, 1'b0, 1'b0);

        //        rst fpc   fic fif fvalc  fvalp  eic eif epc   p c u  xt xppc   xm xcorr
        vecs.push_back(mk(1, 'h100, 7, 1, 'h80,  'h109, 7, 1, 'h100, 0, 1, 1, 1, 'h80,  0, 'h300));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 1, 0, 0, 0, 'h109, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 1, 1, 0, 'h109, 1, 'h300));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 1, 1, 1, 1, 'h200, 0, 'h300));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 1, 0, 1, 1, 'h200, 1, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 1, 0, 1, 1, 'h200, 1, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 0, 1, 0, 'h109, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 0, 1, 0, 'h109, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 1, 1, 0, 'h109, 1, 'h300));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 1, 1, 0, 'h109, 1, 'h300));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 1, 0, 0, 1, 'h200, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 0, 'h100, 1, 0, 1, 1, 'h200, 0, 'h209));
        vecs.push_back(mk(0, 'h150, 7, 0, 'h200, 'h159, 6, 0, 'h100, 1, 0, 1, 1, 'h200, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h110, 0, 0, 1, 1, 'h200, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 7, 1, 'h200, 'h109, 7, 1, 'h100, 0, 0, 0, 0, 'h109, 0, 'h209));
        vecs.push_back(mk(0, 'h110, 7, 1, 'h80,  'h119, 7, 1, 'h100, 0, 0, 0, 0, 'h119, 0, 'h209));
        vecs.push_back(mk(0, 'h100, 2, 0, 'h80,  'h102, 7, 1, 'h100, 0, 0, 0, 0, 'h102, 0, 'h209));

        // initial reset so the table is defined before the first vector
        tick();
        chk("rst_branch_cnt", {32'd0, br_cnt}, 64'd0);
        chk("rst_mispred_cnt", {32'd0, mis_cnt}, 64'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            set_f(vecs[i].fpc, vecs[i].ficode, vecs[i].fifun, vecs[i].fvalc, vecs[i].fvalp);
            e_icode = vecs[i].eicode; e_ifun = vecs[i].eifun; e_pc = vecs[i].epc;
            e_pred = vecs[i].epred; e_cnd = vecs[i].ecnd; upd_en = vecs[i].upd;
            #1;
            chk($sformatf("v%0d taken", i), {63'd0, f_taken}, {63'd0, vecs[i].x_taken});
            chk($sformatf("v%0d predPC", i), f_ppc, vecs[i].x_ppc);
            chk($sformatf("v%0d mispredict", i), {63'd0, e_mis}, {63'd0, vecs[i].x_mis});
            chk($sformatf("v%0d corrPC", i), e_corr, vecs[i].x_corr);
            tick();
        end
        upd_en = 1'b0;
        chk("tbl_branch_cnt", {32'd0, br_cnt}, Stats ? 64'd9 : 64'd0);
        chk("tbl_mispred_cnt", {32'd0, mis_cnt}, Stats ? 64'd5 : 64'd0);

        // reset with a coincident update that would allocate 0x120 as not-taken
        rst = 1'b1;
        set_e(64'h120, 1'b0, 1'b0, 1'b1);
        set_f(64'h120, 4'h7, 4'h1, 64'h80, 64'h129);
        #1;
        chk("rstA_mispredict", {63'd0, e_mis}, 64'd0);
        tick();
        rst = 1'b0; upd_en = 1'b0;
        #1;
        chk("rstA_static_taken", {63'd0, f_taken}, 64'd1);
        chk("rstA_branch_cnt", {32'd0, br_cnt}, 64'd0);
        chk("rstA_mispred_cnt", {32'd0, mis_cnt}, 64'd0);

        // five updates at 0x130, two mispredicts
        for (int k = 0; k < 5; k++) begin
            set_e(64'h130, seq5[k][1], seq5[k][0], 1'b1);
            #1;
            chk($sformatf("s5_%0d mispredict", k), {63'd0, e_mis},
                {63'd0, seq5[k][1] != seq5[k][0]});
            tick();
        end
        upd_en = 1'b0;
        #1;
        chk("s5_branch_cnt", {32'd0, br_cnt}, Stats ? 64'd5 : 64'd0);
        chk("s5_mispred_cnt", {32'd0, mis_cnt}, Stats ? 64'd2 : 64'd0);

        // reset pulse with a coincident taken update at 0x130
        rst = 1'b1;
        set_e(64'h130, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b0; upd_en = 1'b0;
        set_f(64'h130, 4'h7, 4'h1, 64'h200, 64'h139);
        #1;
        chk("rstB_taken", {63'd0, f_taken}, 64'd0);
        chk("rstB_predPC", f_ppc, 64'h139);
        chk("rstB_branch_cnt", {32'd0, br_cnt}, 64'd0);
        chk("rstB_mispred_cnt", {32'd0, mis_cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
